// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 register file, branch/jump resolution, hazard stall, ID/EX register.
// Optional feature: define ID_WB_BYPASS_EN for write-first reads of the WB write port.
module id_stage #(
   parameter int unsigned RF_DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic [31:0] nextPC,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        IDpcSrc,
   output logic [31:0] IDPC,
   output logic        Stall,
   output logic        id_valid,
   output logic [31:0] id_rs_data,
   output logic [31:0] id_rt_data,
   output logic [31:0] id_imm,
   output logic [4:0]  id_rs,
   output logic [4:0]  id_rt,
   output logic [4:0]  id_rd,
   output logic        id_reg_write,
   output logic        id_mem_read,
   output logic        id_mem_write,
   output logic        id_alu_src,
   output logic [5:0]  id_funct,
   output logic        id_illegal
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned FW   = 6;

   localparam logic [FW-1:0] OP_RTYPE = 6'h00;
   localparam logic [FW-1:0] OP_J     = 6'h02;
   localparam logic [FW-1:0] OP_BEQ   = 6'h04;
   localparam logic [FW-1:0] OP_BNE   = 6'h05;
   localparam logic [FW-1:0] OP_ADDI  = 6'h08;
   localparam logic [FW-1:0] OP_LW    = 6'h23;
   localparam logic [FW-1:0] OP_SW    = 6'h2B;
   localparam logic [FW-1:0] FN_ADD   = 6'h20;

   logic [XLEN-1:0] r_rf [RF_DEPTH];

   logic [FW-1:0]   w_op;
   logic [RW-1:0]   w_rs, w_rt, w_rdf;
   logic [15:0]     w_imm16;
   logic [XLEN-1:0] w_imm_sext;
   logic [XLEN-1:0] w_rf_rs, w_rf_rt, w_rs_data, w_rt_data;
   logic            w_uses_rs, w_uses_rt, w_reg_write, w_mem_read, w_mem_write, w_alu_src;
   logic            w_is_beq, w_is_bne, w_is_j, w_illegal;
   logic [RW-1:0]   w_dest;
   logic [FW-1:0]   w_funct;
   logic            w_wb_active, w_ex_hit, w_mem_hit, w_wb_hit;
   logic            w_load_use, w_br_haz, w_wb_haz, w_stall_raw, w_taken, w_bubble;
   logic [XLEN-1:0] w_br_target, w_j_target;

   assign w_op       = instruction[31:26];
   assign w_rs       = instruction[25:21];
   assign w_rt       = instruction[20:16];
   assign w_rdf      = instruction[15:11];
   assign w_imm16    = instruction[15:0];
   assign w_imm_sext = {{16{w_imm16[15]}}, w_imm16};

   // Register file: async reads, write on the rising edge, $0 never written.
   always_ff @(posedge clk or negedge rst_n) begin : rf_write
      if (!rst_n) begin
         for (int i = 0; i < int'(RF_DEPTH); i++) r_rf[i] <= '0;
      end else if (w_wb_active && (32'(wb_rd) < RF_DEPTH)) begin
         r_rf[wb_rd] <= wb_data;
      end
   end

   assign w_wb_active = wb_reg_write && (wb_rd != '0);
   assign w_rf_rs     = (32'(w_rs) < RF_DEPTH) ? r_rf[w_rs] : '0;
   assign w_rf_rt     = (32'(w_rt) < RF_DEPTH) ? r_rf[w_rt] : '0;

`ifdef ID_WB_BYPASS_EN
   assign w_rs_data = (w_wb_active && (wb_rd == w_rs)) ? wb_data : w_rf_rs;
   assign w_rt_data = (w_wb_active && (wb_rd == w_rt)) ? wb_data : w_rf_rt;
`else
   assign w_rs_data = w_rf_rs;
   assign w_rt_data = w_rf_rt;
`endif

   // Opcode decode into register usage and control bits.
   always_comb begin : decode
      w_uses_rs   = 1'b0;
      w_uses_rt   = 1'b0;
      w_dest      = '0;
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_alu_src   = 1'b0;
      w_funct     = '0;
      w_is_beq    = 1'b0;
      w_is_bne    = 1'b0;
      w_is_j      = 1'b0;
      w_illegal   = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_uses_rs   = 1'b1;
            w_uses_rt   = 1'b1;
            w_dest      = w_rdf;
            w_reg_write = (instruction != '0);
            w_funct     = instruction[5:0];
         end
         OP_ADDI: begin
            w_uses_rs   = 1'b1;
            w_dest      = w_rt;
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_funct     = FN_ADD;
         end
         OP_LW: begin
            w_uses_rs   = 1'b1;
            w_dest      = w_rt;
            w_reg_write = 1'b1;
            w_mem_read  = 1'b1;
            w_alu_src   = 1'b1;
            w_funct     = FN_ADD;
         end
         OP_SW: begin
            w_uses_rs   = 1'b1;
            w_uses_rt   = 1'b1;
            w_mem_write = 1'b1;
            w_alu_src   = 1'b1;
            w_funct     = FN_ADD;
         end
         OP_BEQ: begin
            w_uses_rs = 1'b1;
            w_uses_rt = 1'b1;
            w_is_beq  = 1'b1;
         end
         OP_BNE: begin
            w_uses_rs = 1'b1;
            w_uses_rt = 1'b1;
            w_is_bne  = 1'b1;
         end
         OP_J:    w_is_j    = 1'b1;
         default: w_illegal = 1'b1;
      endcase
   end

   // Hazards: a downstream writer matching a source this instruction actually reads.
   assign w_ex_hit  = (ex_rd  != '0) && ((w_uses_rs && (ex_rd  == w_rs)) || (w_uses_rt && (ex_rd  == w_rt)));
   assign w_mem_hit = (mem_rd != '0) && ((w_uses_rs && (mem_rd == w_rs)) || (w_uses_rt && (mem_rd == w_rt)));
   assign w_wb_hit  = (wb_rd  != '0) && ((w_uses_rs && (wb_rd  == w_rs)) || (w_uses_rt && (wb_rd  == w_rt)));

   assign w_load_use = ex_mem_read && w_ex_hit;
   assign w_br_haz   = (w_is_beq || w_is_bne) &&
                       ((ex_reg_write && w_ex_hit) || (mem_reg_write && w_mem_hit));
`ifdef ID_WB_BYPASS_EN
   assign w_wb_haz   = 1'b0;
`else
   assign w_wb_haz   = wb_reg_write && w_wb_hit;
`endif
   assign w_stall_raw = w_load_use || w_br_haz || w_wb_haz;
   assign w_bubble    = w_stall_raw || w_illegal;

   assign w_taken     = (w_is_beq && (w_rs_data == w_rt_data)) ||
                        (w_is_bne && (w_rs_data != w_rt_data)) || w_is_j;
   assign w_br_target = nextPC + {{14{w_imm16[15]}}, w_imm16, 2'b00};
   assign w_j_target  = {nextPC[31:28], instruction[25:0], 2'b00};

   // Fetch feedback is combinational and forced quiet while in reset.
   assign Stall   = rst_n && w_stall_raw;
   assign IDpcSrc = rst_n && !w_stall_raw && w_taken;
   assign IDPC    = !rst_n ? '0 : (w_is_j ? w_j_target : w_br_target);

   // ID/EX pipeline register; stalls and illegal opcodes load an all-zero bubble.
   always_ff @(posedge clk or negedge rst_n) begin : idex_reg
      if (!rst_n || w_bubble) begin
         id_valid     <= 1'b0;
         id_rs_data   <= '0;
         id_rt_data   <= '0;
         id_imm       <= '0;
         id_rs        <= '0;
         id_rt        <= '0;
         id_rd        <= '0;
         id_reg_write <= 1'b0;
         id_mem_read  <= 1'b0;
         id_mem_write <= 1'b0;
         id_alu_src   <= 1'b0;
         id_funct     <= '0;
      end else begin
         id_valid     <= 1'b1;
         id_rs_data   <= w_rs_data;
         id_rt_data   <= w_rt_data;
         id_imm       <= w_imm_sext;
         id_rs        <= w_rs;
         id_rt        <= w_rt;
         id_rd        <= w_dest;
         id_reg_write <= w_reg_write;
         id_mem_read  <= w_mem_read;
         id_mem_write <= w_mem_write;
         id_alu_src   <= w_alu_src;
         id_funct     <= w_funct;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : illegal_flag
      if (!rst_n) id_illegal <= 1'b0;
      else if (w_illegal) id_illegal <= 1'b1;
   end

endmodule
